fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
// - Front-end controller that keeps the instruction queue fed: walks the PC and issues word reads to instruction memory.
// - Pushes returned words into a DEPTH-entry prefetch FIFO; decode consumes them with next/stop semantics.
// - Handles branch redirect (flush plus refetch) and stop (fetch freeze). Sits between instruction memory and decode.
// PARAMETERS
// - ADDR_W    32  PC / memory address width (bytes; instructions are 32-bit, word aligned)
// - DEPTH     8   prefetch FIFO entries; power of two, >=2
// - RESET_PC  0   PC loaded at reset
// PORTS
// - clk          in   1       rising-edge clock
// - rst          in   1       synchronous, active-low reset
// - mem_req      out  1       read request to instruction memory
// - mem_addr     out  ADDR_W  request address, stable while mem_req=1
// - mem_ack      in   1       read data valid / request accepted (same cycle as mem_rdata)
// - mem_rdata    in   32      instruction word
// - redirect     in   1       branch taken: flush and restart at redirect_pc
// - redirect_pc  in   ADDR_W  new PC; bits [1:0] ignored (forced 0)
// - stop         in   1       freeze: no new memory requests issued
// - next         in   1       decode pops head entry when instr_valid=1
// - instr        out  32      FIFO head word; 32'h0 when empty
// - instr_pc     out  ADDR_W  PC of the FIFO head word
// - instr_valid  out  1       FIFO non-empty and no redirect this cycle
// BEHAVIOUR
// - Reset (rst=0 at edge): state=RUN, pc=RESET_PC, FIFO empty, mem_req=0, mem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0.
// - Single outstanding request. mem_req is registered; once high it stays high with mem_addr fixed until the mem_ack edge.
// - States:
//   - RUN: when count<DEPTH and stop=0, assert mem_req with mem_addr=pc next cycle -> WAIT.
//   - WAIT: on mem_ack, push {mem_rdata,mem_addr}, pc+=4, drop mem_req -> RUN.
//   - DISCARD: request in flight when a redirect arrived; on mem_ack drop data, drop mem_req -> RUN.
//   - STOPPED: entered from RUN when stop=1; returns to RUN the cycle after stop=0.
// - Latency: first mem_req in the 1st cycle after rst releases; minimum 2 cycles per fetched word
//   (issue, ack; a new request re-registers the cycle after the ack).
// - Full: no request issued while count==DEPTH. A request issued at count==DEPTH-1 never overflows, because only one is outstanding.
// - Pop: on next && instr_valid the head advances at the edge. next while empty is ignored.
// - Push and pop in the same cycle: count unchanged.
// - Redirect: at the edge, FIFO cleared, pc={redirect_pc[ADDR_W-1:2],2'b0}, instr_valid=0 in the redirect cycle.
//   - With a request in flight -> DISCARD; otherwise -> RUN.
//   - Redirect beats next, mem_ack push, and stop in the same cycle; the acked word is dropped.
//   - Redirect while in DISCARD: latest pc wins, state stays DISCARD.
// - stop while a request is in flight: the request completes and its word is pushed, then -> STOPPED. stop does not block pops.
// - Reset mid-request: all state cleared and mem_req drops. A late mem_ack after reset is ignored (state RUN, mem_req=0).
// - pc wraps modulo 2^ADDR_W with no flag.
// CONFIGURATION
// - FETCH_SEQ_STATS_EN defined: adds outputs stat_fetched[31:0] (words pushed), stat_flushed[31:0] (redirect events),
//   stat_starve[31:0] (cycles with instr_valid=0 and rst=1). All reset to 0, saturate at 32'hFFFF_FFFF.
// - FETCH_SEQ_STATS_EN undefined: ports and counters absent; other behaviour identical.
// TESTING
// - Reset, memory acks 1 cycle after each req with rdata=addr^32'hA5A5_0000, next=0
//   -> requests at 0x0,0x4,...,0x1C, then mem_req stays 0 with count=8.
// - From full, next=1 for 8 cycles -> instr 0xA5A5_0000,0xA5A5_0004,...,0xA5A5_001C in order, instr_pc matching;
//   refill resumes at 0x20.
// - Redirect to 0x103 while a req to 0x10 is outstanding, ack 2 cycles later -> that word is discarded,
//   next req is at 0x100, first valid instr_pc=0x100.
// - redirect, next and mem_ack in the same cycle with count=3 -> count=0, nothing popped, acked word dropped.
// - stop=1 during an outstanding req -> word pushed, no further req until 1 cycle after stop=0; pops continue throughout.
// - rst=0 for 1 cycle mid-request, then mem_ack -> mem_req=0, FIFO empty, next req at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch front-end: walks the PC, issues single-outstanding word reads and buffers them in a prefetch FIFO.
// Optional statistics counters are built when FETCH_SEQ_STATS_EN is defined.
module fetch_sequencer #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stop,
  input  logic              next,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
`ifdef FETCH_SEQ_STATS_EN
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_flushed,
  output logic [31:0]       stat_starve,
`endif
  output logic [1:0]        dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DISCARD, S_STOPPED} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       data_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];

  logic              push, pop, ack_in, empty;
  logic [ADDR_W-1:0] redirect_addr;

  // Memory handshake: mem_req rises with a registered mem_addr and both hold
  // until the clock edge at which mem_ack=1; that edge completes the read.
  assign ack_in        = mem_ack && mem_req_q;
  assign redirect_addr = redirect_pc & ~(ADDR_W'(3));
  assign empty         = (count_q == '0);
  assign instr_valid   = !empty && !redirect;
  assign pop           = next && instr_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    case (state_q)
      S_RUN: begin
        if (redirect) begin
          pc_d = redirect_addr;
        end else if (stop) begin
          state_d = S_STOPPED;
        end else if (count_q != DEPTH_C) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          // An ack in the redirect cycle retires the request; otherwise its data must be swallowed.
          pc_d = redirect_addr;
          if (ack_in) begin
            mem_req_d = 1'b0;
            state_d   = S_RUN;
          end else begin
            state_d = S_DISCARD;
          end
        end else if (ack_in) begin
          push      = 1'b1;
          pc_d      = pc_q + ADDR_W'(4);
          mem_req_d = 1'b0;
          state_d   = stop ? S_STOPPED : S_RUN;
        end
      end
      S_DISCARD: begin
        if (redirect) pc_d = redirect_addr;
        if (ack_in) begin
          mem_req_d = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_STOPPED: begin
        if (redirect) begin
          pc_d    = redirect_addr;
          state_d = S_RUN;
        end else if (!stop) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= mem_rdata;
      addr_q[wr_ptr_q] <= mem_addr_q;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign instr     = empty ? 32'h0 : data_q[rd_ptr_q];
  assign instr_pc  = empty ? '0 : addr_q[rd_ptr_q];
  assign dbg_state = state_q;

`ifdef FETCH_SEQ_STATS_EN
  logic [31:0] fetched_q, flushed_q, starve_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
      starve_q  <= '0;
    end else begin
      if (push && fetched_q != '1)        fetched_q <= fetched_q + 32'd1;
      if (redirect && flushed_q != '1)    flushed_q <= flushed_q + 32'd1;
      if (!instr_valid && starve_q != '1) starve_q  <= starve_q + 32'd1;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushed = flushed_q;
  assign stat_starve  = starve_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
